divrem_seq: RTL and testbench
=============================

# divrem_seq

Sequential restoring divider for the examples suite. Consumes the 8-bit output of the 4×4 multiplier `mult` as a dividend and divides it by a 4-bit divisor over eight clock cycles. Produces an 8-bit quotient, a 4-bit remainder and an `exact` flag. Benches use it to check multiplier results and factorizations by re-dividing the product.

## Interface
- Parameters: none. Widths are fixed: 8-bit dividend, 4-bit divisor, 8-bit quotient, 4-bit remainder.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a division; sampled on the rising edge of `clk`.
- `dividend`  input  8  dividend (a multiplier product); sampled with `start`.
- `divisor`  input  4  divisor; sampled with `start`.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  one-cycle pulse; result outputs are updated in the same cycle.
- `quotient`  output  8  quotient of the most recently completed division.
- `remainder`  output  4  remainder of the most recently completed division.
- `exact`  output  1  high when `remainder` == 0 and `div_by_zero` == 0.
- `div_by_zero`  output  1  high when the most recent division had `divisor` == 0.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs 8 iterations, tracked by a 3-bit counter `step` running 0..7.
- Reset (asynchronous): state=IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `exact`=0, `div_by_zero`=0; all working registers cleared.
- IDLE with `start`=1 and `divisor`≠0:
  - latch `dividend` into working quotient register `wq`;
  - latch `divisor` into `wd`;
  - clear 5-bit partial remainder `pr` and set `step`=0;
  - go to RUN; `busy`=1.
- IDLE with `start`=1 and `divisor`==0:
  - no RUN phase; at the same edge set `quotient`=8'hFF, `remainder`=`dividend[3:0]`, `div_by_zero`=1, `exact`=0, `done`=1;
  - state stays IDLE and `busy` stays 0.
- RUN, each cycle (restoring step):
  - t = {`pr[3:0]`, `wq[7]`}, 5 bits;
  - if t ≥ {1'b0, `wd`}: `pr` = t − `wd`, shift `wq` left inserting 1;
  - else: `pr` = t, shift `wq` left inserting 0;
  - `step` increments.
- RUN, iteration with `step`==7: also register `quotient` = final `wq`, `remainder` = final `pr[3:0]`, `exact` = (final `pr`==0), `div_by_zero`=0, `done`=1; return to IDLE; `busy`=0.
- `done` deasserts on the next edge unconditionally.
- Result outputs change only at completion and hold until the next completion.
- `start` while in RUN is ignored: it is not queued and the operands are not resampled.
- `start` in the cycle where `done`=1 (state is IDLE) is accepted normally.
- Arithmetic invariant at completion: `quotient`·`divisor` + `remainder` == `dividend`, with `remainder` < `divisor`. `pr` never exceeds 4 significant bits after subtraction.

## Timing
- Latency, normal case: `start` accepted at edge E0. `busy` is high from E0 to E8. `done` and the results are valid after E8 for exactly one cycle (`done`), and the results persist after that. Eight edges from accept to `done`.
- Latency, divide-by-zero: `done` is high after E0, a one-cycle latency.
- Throughput: one division per 9 cycles when `start` is raised during the `done` cycle.
- Reset mid-RUN: abort immediately. All outputs take their reset values; no `done` pulse follows.
- Inputs need only be stable at the accepting edge.

## Test plan
- Reset, then `dividend`=143, `divisor`=13, one-cycle `start` -> `busy` high 8 cycles, then `done` pulse with `quotient`=11, `remainder`=0, `exact`=1, `div_by_zero`=0.
- `dividend`=200, `divisor`=7 -> after 8 cycles `quotient`=28, `remainder`=4, `exact`=0; outputs still hold 28/4 five cycles later.
- Boundaries: 255/1 -> 255 r0. 255/15 -> 17 r0. 0/9 -> 0 r0 with `exact`=1. 14/15 -> 0 r14.
- `divisor`=0, `dividend`=8'hA6 -> `done` on the next cycle with `quotient`=8'hFF, `remainder`=6, `div_by_zero`=1, and `busy` never rises. Follow with 6/3 -> `div_by_zero` clears, `quotient`=2.
- Start 143/13, pulse `start` with 50/5 at step 3 -> the second request is ignored and the result is 11 r0. Then raise `start` with 50/5 during the `done` cycle -> 10 r0 eight cycles later.
- Start 200/7, assert `reset` at step 4 -> all outputs 0 immediately, no `done`. After `reset` is released, 100/9 -> 11 r1.

Source files
------------

// File: rtl/divrem_seq_if.sv
// Request/result bundle for the sequential 8-by-4 divider.
// The master drives operands and start; the slave returns status and results.
interface divrem_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       exact;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, exact, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, exact, div_by_zero
  );
endinterface

// File: rtl/divrem_seq.sv
// Restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per cycle.
// Divide-by-zero is resolved in the accepting cycle without entering RUN.
module divrem_seq (
  input  logic          clk,
  input  logic          reset,
  divrem_seq_if.slave   io
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] wq_q, wq_d;
  logic [3:0] wd_q, wd_d;
  logic [4:0] pr_q, pr_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       exact_q, exact_d;
  logic       dbz_q, dbz_d;
  logic       done_q, done_d;

  // One restoring iteration; pr stays below wd so t never exceeds 5 bits.
  logic [4:0] t;
  logic       ge;
  logic [4:0] pr_nxt;
  logic [7:0] wq_nxt;

  always_comb begin
    t      = {pr_q[3:0], wq_q[7]};
    ge     = (t >= {1'b0, wd_q});
    pr_nxt = ge ? (t - {1'b0, wd_q}) : t;
    wq_nxt = {wq_q[6:0], ge};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wq_d    = wq_q;
    wd_d    = wd_q;
    pr_d    = pr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          if (io.divisor != 4'd0) begin
            wq_d    = io.dividend;
            wd_d    = io.divisor;
            pr_d    = 5'd0;
            step_d  = 3'd0;
            state_d = RUN;
          end else begin
            quot_d  = 8'hFF;
            rem_d   = io.dividend[3:0];
            dbz_d   = 1'b1;
            exact_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        pr_d   = pr_nxt;
        wq_d   = wq_nxt;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          quot_d  = wq_nxt;
          rem_d   = pr_nxt[3:0];
          exact_d = (pr_nxt == 5'd0);
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      wq_q    <= 8'd0;
      wd_q    <= 4'd0;
      pr_q    <= 5'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      exact_q <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wq_q    <= wq_d;
      wd_q    <= wd_d;
      pr_q    <= pr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign io.busy        = (state_q == RUN);
  assign io.done        = done_q;
  assign io.quotient    = quot_q;
  assign io.remainder   = rem_q;
  assign io.exact       = exact_q;
  assign io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divrem_seq.sv
// Bench for divrem_seq: vector table plus hand-written corner sequences,
// expected results queued at issue and compared when done pulses.
module tb_divrem_seq;

  logic clk;
  logic reset;
  divrem_seq_if dif ();

  divrem_seq dut (.clk(clk), .reset(reset), .io(dif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] q;
    logic [3:0] r;
    logic       ex;
    logic       dbz;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [3:0] b);
    vec_t v;
    v.dividend = a;
    v.divisor  = b;
    if (b == 4'd0) begin
      v.q = 8'hFF; v.r = a[3:0]; v.ex = 1'b0; v.dbz = 1'b1;
    end else begin
      v.q = a / b; v.r = 4'(a % b); v.ex = ((a % b) == 0); v.dbz = 1'b0;
    end
    return v;
  endfunction

  // Called at a negedge with start already driven; waits for done, then
  // compares against the scoreboard head. pulse_at>0 injects a stray start.
  task automatic wait_result(input string nm, input int pulse_at, output int lat, output int bcnt);
    vec_t e;
    logic got;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      dif.start = 1'b0;
      lat++;
      if (dif.busy) bcnt++;
      if (dif.done) got = 1'b1;
      if (!got && lat == pulse_at) begin
        dif.start = 1'b1; dif.dividend = 8'd50; dif.divisor = 4'd5;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles", nm, lat);
    end else if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: done with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " quotient"},  dif.quotient,    e.q);
      chk({nm, " remainder"}, dif.remainder,   e.r);
      chk({nm, " exact"},     dif.exact,       e.ex);
      chk({nm, " dbz"},       dif.div_by_zero, e.dbz);
    end
  endtask

  task automatic do_op(input string nm, input vec_t e);
    int lat, bcnt;
    sb.push_back(e);
    dif.start = 1'b1; dif.dividend = e.dividend; dif.divisor = e.divisor;
    wait_result(nm, 0, lat, bcnt);
    chk({nm, " latency"}, lat,  (e.divisor == 0) ? 1 : 9);
    chk({nm, " busy"},    bcnt, (e.divisor == 0) ? 0 : 8);
  endtask

  vec_t tbl[8];
  int   lat, bcnt;
  logic saw_done;

  initial begin
    tbl[0] = '{8'd143, 4'd13, 8'd11,  4'd0,  1'b1, 1'b0};
    tbl[1] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 1'b0};
    tbl[2] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b1, 1'b0};
    tbl[3] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b1, 1'b0};
    tbl[4] = '{8'd0,   4'd9,  8'd0,   4'd0,  1'b1, 1'b0};
    tbl[5] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 1'b0};
    tbl[6] = '{8'hA6,  4'd0,  8'hFF,  4'd6,  1'b0, 1'b1};
    tbl[7] = '{8'd6,   4'd3,  8'd2,   4'd0,  1'b1, 1'b0};

    dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 4'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", dif.busy, 0);
    chk("rst done", dif.done, 0);
    chk("rst quotient", dif.quotient, 0);
    chk("rst remainder", dif.remainder, 0);
    chk("rst exact", dif.exact, 0);
    chk("rst dbz", dif.div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Results hold after completion and done is a single pulse.
    do_op("hold", tbl[1]);
    @(negedge clk);
    chk("hold done drop", dif.done, 0);
    repeat (4) @(negedge clk);
    chk("hold quotient", dif.quotient, 28);
    chk("hold remainder", dif.remainder, 4);

    // Stray start during RUN at step 3, then a start in the done cycle.
    sb.push_back(tbl[0]);
    dif.start = 1'b1; dif.dividend = 8'd143; dif.divisor = 4'd13;
    wait_result("ignore", 4, lat, bcnt);
    chk("ignore latency", lat, 9);
    chk("ignore queue", sb.size(), 0);
    do_op("b2b", '{8'd50, 4'd5, 8'd10, 4'd0, 1'b1, 1'b0});

    for (int i = 0; i < 16; i++)
      do_op($sformatf("rnd%0d", i), model(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15))));

    // Reset at step 4 aborts without a done pulse.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 8'd200; dif.divisor = 4'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", dif.busy, 0);
    chk("abort done", dif.done, 0);
    chk("abort quotient", dif.quotient, 0);
    chk("abort remainder", dif.remainder, 0);
    chk("abort exact", dif.exact, 0);
    chk("abort dbz", dif.div_by_zero, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dif.done) saw_done = 1'b1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dif.done) saw_done = 1'b1;
    end
    chk("abort no done", saw_done, 0);
    do_op("post_rst", '{8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 1'b0});

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
